rally_ctrl: RTL
===============

Name: rally_ctrl

Overview:
- Match sequencer for the volley game. Sits between the collision/ball logic (ball_pos_ctrl) and the display and score logic.
- Watches player and ground collisions and ball x position, and enforces the touch limit per side.
- Awards points and keeps scores.
- Drives ball freeze and re-serve to ball_pos_ctrl, with pauses between rallies and a game-over state.

Parameters:
NET_X, 12'd400, ball x strictly below this is player-1 half; else player-2 half
MAX_TOUCH, 3, legal consecutive touches per side; touch MAX_TOUCH+1 is a fault
WIN_SCORE, 15, score that ends the game (no win-by-2)
PAUSE_FRAMES, 90, frame ticks of freeze after a point
SCORE_W, 5, score counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
start  in  1  level; begins a match from IDLE or OVER
ball_posx  in  12  current ball x from ball_pos_ctrl
gnd_col  in  1  level; ball touching ground
pl1_col  in  1  level; ball touching player 1
pl2_col  in  1  level; ball touching player 2
ball_hold  out  1  freeze ball motion
ball_rst  out  1  one-cycle pulse; reload ball at server start position
serve_side  out  1  0 = player 1 serves, 1 = player 2 serves
score1  out  SCORE_W  player-1 score
score2  out  SCORE_W  player-2 score
point_pulse  out  1  one-cycle pulse when a point is awarded
point_side  out  1  winner of the last point (0 = pl1, 1 = pl2)
game_over  out  1  match finished

Behaviour:
- All outputs are registered. Reset applies on the clk edge where rst=1, including mid-rally.
- Reset values:
  - state IDLE; ball_hold=1; ball_rst=0; serve_side=0.
  - score1=score2=0; point_pulse=0; point_side=0; game_over=0.
  - touch counters cnt1=cnt2=0; edge registers=0.
- Edge detection:
  - Rising edge of pl1_col, pl2_col and gnd_col is input AND NOT its previous-cycle register.
  - An input high in the first cycle after reset counts as an edge.
- IDLE:
  - ball_hold=1.
  - start=1 -> SERVE; ball_rst=1 for exactly that transition cycle.
- SERVE:
  - ball_hold=1.
  - Rising edge of the server's collision -> RALLY; server count=1, other count=0.
  - Collisions from the non-server, and gnd_col, are ignored.
- RALLY: ball_hold=0. Per cycle, in priority order:
  1. gnd edge: ball_posx<NET_X gives the point to pl2; otherwise the point goes to pl1. Go to POINT.
  2. Both player edges in the same cycle: cnt1=cnt2=1; no fault.
  3. Single plN edge: if cntN==MAX_TOUCH, fault and the point goes to the opponent (POINT). Otherwise cntN+1, and the opponent count becomes 0.
- Point award, on the cycle RALLY->POINT:
  - point_pulse=1 for one cycle; point_side=winner.
  - Winner score +1, saturating at WIN_SCORE.
  - Pause counter cleared.
- POINT:
  - ball_hold=1. Pause counter increments on frame_tick; no other events are processed.
  - When the counter reaches PAUSE_FRAMES:
    - If the winner score == WIN_SCORE -> OVER.
    - Otherwise -> SERVE with serve_side=point_side, cnt1=cnt2=0, and a one-cycle ball_rst.
- OVER:
  - game_over=1, ball_hold=1; scores held.
  - start=1 -> scores=0, game_over=0, serve_side=0, ball_rst pulse, then SERVE.
- Timing and state rules:
  - start is ignored in SERVE, RALLY and POINT.
  - ball_rst and point_pulse never assert in the same cycle.
  - Latency from an input edge to the output change is 1 clk.

Test Plan:
- Reset then start=1 for 1 cycle -> ball_rst high exactly 1 cycle; state SERVE; ball_hold=1; serve_side=0; scores 0/0.
- In SERVE:
  - pl2_col pulse -> no effect.
  - Then pl1_col rises -> ball_hold=0 next cycle.
  - Then gnd_col rises with ball_posx=12'd600 -> point_pulse one cycle, point_side=0, score1=1.
  - After 90 frame_ticks -> ball_rst pulse, serve_side=0.
- In RALLY, after the serve touch (cnt1=1), give pl1_col 3 more rising edges -> 3rd extra edge (4th touch) gives the point to pl2: score2=1, point_side=1, next serve_side=1.
- Alternate touches pl1, pl1, pl2, pl2, pl2, pl1 -> no fault. Then gnd_col with ball_posx=12'd399 -> point to pl2.
- gnd_col and pl1_col rise in the same cycle with ball_posx=12'd100 -> ground wins; point to pl2, touch ignored.
- Set WIN_SCORE=2 and play 2 pl1 points -> game_over=1 after the pause; start -> scores 0/0, ball_rst pulse.
- Assert rst mid-RALLY -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/rally_ctrl.sv
// rally_ctrl -- match sequencer for the volley game.
//
// Sits between the ball/collision logic (ball_pos_ctrl) and the display and
// score logic. It watches player and ground contacts, enforces the touch limit
// on each side, awards points, keeps both scores, and freezes or re-serves the
// ball between rallies until one player reaches the winning score.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   frame_tick   one-cycle pulse per video frame (paces the post-point pause)
//   start        level; begins a match from IDLE or OVER
//   ball_posx    current ball x position from ball_pos_ctrl
//   gnd_col      level; ball touching the ground
//   pl1_col      level; ball touching player 1
//   pl2_col      level; ball touching player 2
//   ball_hold    freeze ball motion (low only while a rally is live)
//   ball_rst     one-cycle pulse; reload ball at the server start position
//   serve_side   0 = player 1 serves, 1 = player 2 serves
//   score1       player-1 score
//   score2       player-2 score
//   point_pulse  one-cycle pulse when a point is awarded
//   point_side   winner of the last point (0 = pl1, 1 = pl2)
//   game_over    match finished

module rally_ctrl #(
   parameter logic [11:0] NET_X        = 12'd400,
   parameter int          MAX_TOUCH    = 3,
   parameter int          WIN_SCORE    = 15,
   parameter int          PAUSE_FRAMES = 90,
   parameter int          SCORE_W      = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               start,
   input  logic [11:0]        ball_posx,
   input  logic               gnd_col,
   input  logic               pl1_col,
   input  logic               pl2_col,
   output logic               ball_hold,
   output logic               ball_rst,
   output logic               serve_side,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic               point_pulse,
   output logic               point_side,
   output logic               game_over
);

   localparam int CNT_W   = $clog2(MAX_TOUCH + 1);
   localparam int PAUSE_W = $clog2(PAUSE_FRAMES + 1);

   localparam logic [CNT_W-1:0]   MAX_VAL   = CNT_W'(MAX_TOUCH);
   localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
   localparam logic [PAUSE_W-1:0] PAUSE_VAL = PAUSE_W'(PAUSE_FRAMES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SERVE,
      S_RALLY,
      S_POINT,
      S_OVER
   } state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0]   cnt1, cnt2, cnt1_nxt, cnt2_nxt;
   logic [PAUSE_W-1:0] pause_cnt, pause_nxt;
   logic [SCORE_W-1:0] score1_nxt, score2_nxt;

   logic pl1_q, pl2_q, gnd_q;
   logic pl1_edge, pl2_edge, gnd_edge;

   logic ball_hold_nxt, ball_rst_nxt, serve_side_nxt;
   logic point_pulse_nxt, point_side_nxt, game_over_nxt;
   logic award, award_side;

   // Contacts are levels that stay high for several cycles while the ball
   // overlaps a sprite, so only the first cycle of each contact counts.
   // The history registers clear on reset, which makes an input that is
   // already high right after reset register as a fresh contact.
   assign pl1_edge = pl1_col & ~pl1_q;
   assign pl2_edge = pl2_col & ~pl2_q;
   assign gnd_edge = gnd_col & ~gnd_q;

   // Next-state and next-output logic. Every output is computed here and
   // registered below, so each visible change lags its cause by one clock.
   // A point award is collected in 'award'/'award_side' from whichever RALLY
   // rule fired and applied once after the case, so scoring has one home.
   always_comb begin
      state_nxt       = state;
      cnt1_nxt        = cnt1;
      cnt2_nxt        = cnt2;
      pause_nxt       = pause_cnt;
      score1_nxt      = score1;
      score2_nxt      = score2;
      serve_side_nxt  = serve_side;
      point_side_nxt  = point_side;
      game_over_nxt   = game_over;
      ball_rst_nxt    = 1'b0;
      point_pulse_nxt = 1'b0;
      award           = 1'b0;
      award_side      = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt    = S_SERVE;
               ball_rst_nxt = 1'b1;
            end
         end

         // Only the server's own contact puts the ball in play; the first
         // touch counts against the server's side.
         S_SERVE: begin
            if (serve_side ? pl2_edge : pl1_edge) begin
               state_nxt = S_RALLY;
               cnt1_nxt  = serve_side ? '0 : CNT_W'(1);
               cnt2_nxt  = serve_side ? CNT_W'(1) : '0;
            end
         end

         // Ground contact outranks any player contact in the same cycle.
         // A simultaneous touch by both players is treated as a fresh
         // exchange and can never be a fault.
         S_RALLY: begin
            if (gnd_edge) begin
               award      = 1'b1;
               award_side = (ball_posx < NET_X);
            end else if (pl1_edge && pl2_edge) begin
               cnt1_nxt = CNT_W'(1);
               cnt2_nxt = CNT_W'(1);
            end else if (pl1_edge) begin
               if (cnt1 == MAX_VAL) begin
                  award      = 1'b1;
                  award_side = 1'b1;
               end else begin
                  cnt1_nxt = cnt1 + 1'b1;
                  cnt2_nxt = '0;
               end
            end else if (pl2_edge) begin
               if (cnt2 == MAX_VAL) begin
                  award      = 1'b1;
                  award_side = 1'b0;
               end else begin
                  cnt2_nxt = cnt2 + 1'b1;
                  cnt1_nxt = '0;
               end
            end
         end

         // The pause ends one clock after the counter reaches its target;
         // the winner of the point then serves unless the match is decided.
         S_POINT: begin
            if (pause_cnt == PAUSE_VAL) begin
               if ((point_side ? score2 : score1) == WIN_VAL) begin
                  state_nxt     = S_OVER;
                  game_over_nxt = 1'b1;
               end else begin
                  state_nxt      = S_SERVE;
                  serve_side_nxt = point_side;
                  cnt1_nxt       = '0;
                  cnt2_nxt       = '0;
                  ball_rst_nxt   = 1'b1;
               end
            end else if (frame_tick) begin
               pause_nxt = pause_cnt + 1'b1;
            end
         end

         S_OVER: begin
            if (start) begin
               state_nxt      = S_SERVE;
               score1_nxt     = '0;
               score2_nxt     = '0;
               game_over_nxt  = 1'b0;
               serve_side_nxt = 1'b0;
               cnt1_nxt       = '0;
               cnt2_nxt       = '0;
               ball_rst_nxt   = 1'b1;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      if (award) begin
         state_nxt       = S_POINT;
         point_pulse_nxt = 1'b1;
         point_side_nxt  = award_side;
         pause_nxt       = '0;
         if (award_side) begin
            score2_nxt = (score2 == WIN_VAL) ? score2 : score2 + 1'b1;
         end else begin
            score1_nxt = (score1 == WIN_VAL) ? score1 : score1 + 1'b1;
         end
      end

      ball_hold_nxt = (state_nxt != S_RALLY);
   end

   // State, counters, contact history and all outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt1        <= '0;
         cnt2        <= '0;
         pause_cnt   <= '0;
         pl1_q       <= 1'b0;
         pl2_q       <= 1'b0;
         gnd_q       <= 1'b0;
         ball_hold   <= 1'b1;
         ball_rst    <= 1'b0;
         serve_side  <= 1'b0;
         score1      <= '0;
         score2      <= '0;
         point_pulse <= 1'b0;
         point_side  <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt1        <= cnt1_nxt;
         cnt2        <= cnt2_nxt;
         pause_cnt   <= pause_nxt;
         pl1_q       <= pl1_col;
         pl2_q       <= pl2_col;
         gnd_q       <= gnd_col;
         ball_hold   <= ball_hold_nxt;
         ball_rst    <= ball_rst_nxt;
         serve_side  <= serve_side_nxt;
         score1      <= score1_nxt;
         score2      <= score2_nxt;
         point_pulse <= point_pulse_nxt;
         point_side  <= point_side_nxt;
         game_over   <= game_over_nxt;
      end
   end

endmodule
